issue_sched: RTL and testbench

Dual-issue scheduler between instruction fetch and the decode stage. Accepts one 64-bit bundle per cycle: upper slot [63:32], lower slot [31:0]. Presents the bundle to decode either intact or as two sequential single-slot bundles. Drives decode's `interlock`, covering load-use hazards through a per-register scoreboard and external stalls.

---
 rtl/issue_sched_if.sv | 22 ++
 rtl/issue_sched.sv | 127 ++++++++++++
 tb/tb_issue_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/issue_sched_if.sv
// Fetch/decode handshake bundle for the dual-issue scheduler.
interface issue_sched_if;
    logic        f_valid;
    logic [63:0] f_inst;
    logic        f_ready;
    logic [63:0] d_inst;
    logic        interlock;
    logic        ext_stall;
    logic        flush;

    // Environment side: fetch plus downstream control.
    modport master (
        output f_valid, f_inst, ext_stall, flush,
        input  f_ready, d_inst, interlock
    );

    // Scheduler side.
    modport slave (
        input  f_valid, f_inst, ext_stall, flush,
        output f_ready, d_inst, interlock
    );
endinterface

// File: rtl/issue_sched.sv
// Dual-issue scheduler: splits hazardous bundles, tracks load latency per
// register and raises the decode interlock.
module issue_sched #(
    parameter int LOAD_LAT = 2
) (
    input  logic         clk,
    input  logic         rstn,
    issue_sched_if.slave bus
);
    localparam logic [31:0] NOP = {3'b111, 29'b0};

    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b010001;
    localparam logic [5:0] OP_LI    = 6'b010010;
    localparam logic [5:0] OP_LIW   = 6'b010011;
    // Jump/Blr share the branch block with Bl/Blrr.
    localparam logic [5:0] OP_JUMP  = 6'b011000;
    localparam logic [5:0] OP_BLR   = 6'b011001;
    localparam logic [5:0] OP_BL    = 6'b011010;
    localparam logic [5:0] OP_BLRR  = 6'b011011;
    localparam logic [5:0] OP_WIDE  = 6'b100000;
    localparam logic [2:0] LAT3     = 3'(LOAD_LAT);

    typedef enum logic {PASS, SPLIT_LO} state_t;

    function automatic logic has_dst(input logic [31:0] s);
        logic [5:0] op;
        op = s[31:26];
        return (op <= 6'b000101) || op == OP_LI || op == OP_LIW || op == OP_LOAD ||
               (op >= 6'b101000 && op <= 6'b101011) || op == OP_BL || op == OP_BLRR;
    endfunction

    function automatic logic [4:0] dst(input logic [31:0] s);
        return (s[31:26] == OP_BL || s[31:26] == OP_BLRR) ? 5'd31 : s[25:21];
    endfunction

    function automatic logic bundle_only(input logic [5:0] op);
        return op == OP_LIW || op == OP_JUMP || op == OP_BLR || op == OP_BL ||
               op == OP_BLRR || op == OP_WIDE;
    endfunction

    // NOP slots read nothing; Store additionally reads rs.
    function automatic logic reads(input logic [31:0] s, input logic [4:0] r);
        if (s == NOP) return 1'b0;
        return s[20:16] == r || s[15:11] == r || (s[31:26] == OP_STORE && s[25:21] == r);
    endfunction

    function automatic logic src_busy(input logic [31:0] s, input logic [31:0][2:0] cnt);
        if (s == NOP) return 1'b0;
        return cnt[s[20:16]] != 3'd0 || cnt[s[15:11]] != 3'd0 ||
               (s[31:26] == OP_STORE && cnt[s[25:21]] != 3'd0);
    endfunction

    state_t             state_q, state_d;
    logic [31:0][2:0]   cnt_q, cnt_d;
    logic [31:0]        hi, lo_eff, slot_hi, slot_lo;
    logic [63:0]        d_view;
    logic               split, stall, issue;

    assign hi     = bus.f_inst[63:32];
    assign lo_eff = bundle_only(hi[31:26]) ? NOP : bus.f_inst[31:0];
    assign issue  = rstn && !bus.flush && !stall;

    // State and scoreboard registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= PASS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Split decision, presented bundle, slots under check and stall.
    always_comb begin
        split = (has_dst(hi) && reads(lo_eff, dst(hi))) ||
                (has_dst(hi) && has_dst(lo_eff) && dst(hi) == dst(lo_eff)) ||
                lo_eff[31:26] == OP_LOAD || lo_eff[31:26] == OP_STORE;
        d_view  = {hi, NOP};
        slot_hi = hi;
        slot_lo = NOP;
        if (state_q == SPLIT_LO) begin
            d_view  = {bus.f_inst[31:0], NOP};
            slot_hi = bus.f_inst[31:0];
        end else if (!split) begin
            d_view  = bus.f_inst;
            slot_lo = lo_eff;
        end
        stall = src_busy(slot_hi, cnt_q) || src_busy(slot_lo, cnt_q) ||
                bus.ext_stall || (state_q == PASS && !bus.f_valid);
    end

    // Next state: flush and reset return to PASS, stalls hold.
    always_comb begin
        state_d = state_q;
        if (!rstn || bus.flush)
            state_d = PASS;
        else if (issue)
            state_d = (state_q == PASS && split) ? SPLIT_LO : PASS;
    end

    // Decode-facing outputs.
    always_comb begin
        bus.d_inst    = d_view;
        bus.interlock = 1'b1;
        bus.f_ready   = 1'b0;
        if (!rstn) begin
            bus.d_inst = {NOP, NOP};
        end else if (bus.flush) begin
            bus.f_ready = 1'b1;
        end else if (issue) begin
            bus.interlock = 1'b0;
            bus.f_ready   = (state_q == SPLIT_LO) || !split;
        end
    end

    // Scoreboard: count down every cycle; an issued Load (only ever in the
    // upper presented slot) reloads its rt and wins over the decrement.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : 3'd0;
            if (issue && d_view[63:58] == OP_LOAD && d_view[57:53] == 5'(i))
                cnt_d[i] = LAT3;
        end
    end
endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched with LOAD_LAT = 2.
module tb_issue_sched;
    localparam logic [31:0] NOP   = {3'b111, 29'b0};
    localparam logic [5:0]  ADDI  = 6'b000000;
    localparam logic [5:0]  ADD   = 6'b000010;
    localparam logic [5:0]  SUB   = 6'b000011;
    localparam logic [5:0]  LOAD  = 6'b010000;
    localparam logic [5:0]  STORE = 6'b010001;
    localparam logic [5:0]  LIW   = 6'b010011;

    logic clk = 1'b0;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    issue_sched_if bus ();
    issue_sched #(.LOAD_LAT(2)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [5:0] op, input int rt, input int ra, input int rb);
        return {op, 5'(rt), 5'(ra), 5'(rb), 11'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance one clock edge.
    task automatic step(input string tag, input logic [63:0] d, input logic il, input logic fr);
        @(negedge clk);
        chk({tag, ".d_inst"}, bus.d_inst, d);
        chk({tag, ".interlock"}, 64'(bus.interlock), 64'(il));
        chk({tag, ".f_ready"}, 64'(bus.f_ready), 64'(fr));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] h, l;
    logic [63:0] f;

    initial begin
        rstn = 1'b0;
        bus.f_valid = 1'b0; bus.f_inst = {NOP, NOP};
        bus.ext_stall = 1'b0; bus.flush = 1'b0;
        step("rst0", {NOP, NOP}, 1, 0);
        step("rst1", {NOP, NOP}, 1, 0);
        rstn = 1'b1;
        step("idle", {NOP, NOP}, 1, 0);

        // independent bundle issues intact
        bus.f_valid = 1'b1;
        f = {ins(ADDI, 1, 2, 0) | 32'd5, ins(ADD, 3, 4, 5)}; bus.f_inst = f;
        step("indep", f, 0, 1);
        bus.ext_stall = 1'b1;
        step("es_pass", f, 1, 0);
        bus.ext_stall = 1'b0;

        // intra-bundle RAW splits
        h = ins(ADDI, 1, 0, 0) | 32'd1; l = ins(ADD, 2, 1, 1); bus.f_inst = {h, l};
        step("raw_hi", {h, NOP}, 0, 0);
        step("raw_lo", {l, NOP}, 0, 1);

        // WAW split with a stall while the lower half is pending
        h = ins(ADD, 6, 1, 2); l = ins(SUB, 6, 3, 4); bus.f_inst = {h, l};
        step("waw_hi", {h, NOP}, 0, 0);
        bus.ext_stall = 1'b1;
        step("waw_stall", {l, NOP}, 1, 0);
        bus.ext_stall = 1'b0;
        step("waw_lo", {l, NOP}, 0, 1);

        // Store in the lower slot splits
        h = ins(ADD, 1, 2, 3); l = ins(STORE, 3, 4, 5); bus.f_inst = {h, l};
        step("st_hi", {h, NOP}, 0, 0);
        step("st_lo", {l, NOP}, 0, 1);

        // load-use: lower Load splits, dependent waits two cycles
        l = ins(LOAD, 7, 2, 0); bus.f_inst = {NOP, l};
        step("ld_hi", {NOP, NOP}, 0, 0);
        step("ld_lo", {l, NOP}, 0, 1);
        f = {ins(ADD, 8, 7, 0), NOP}; bus.f_inst = f;
        step("use1", f, 1, 0);
        step("use2", f, 1, 0);
        step("use_go", f, 0, 1);

        // Liw upper: no split, lower Load ignored by the scoreboard
        f = {ins(LIW, 10, 0, 0), ins(LOAD, 9, 1, 0)}; bus.f_inst = f;
        step("liw", f, 0, 1);
        f = {ins(ADD, 11, 9, 0), NOP}; bus.f_inst = f;
        step("liw_nosb", f, 0, 1);

        // flush in PASS keeps the scoreboard
        f = {ins(LOAD, 12, 1, 0), NOP}; bus.f_inst = f;
        step("ld12", f, 0, 1);
        f = {ins(ADD, 13, 12, 0), NOP}; bus.f_inst = f;
        bus.flush = 1'b1;
        step("flush_pass", f, 1, 1);
        bus.flush = 1'b0;
        step("sb_kept", f, 1, 0);
        step("sb_go", f, 0, 1);

        // Store rs operand is a source
        f = {ins(LOAD, 14, 1, 0), NOP}; bus.f_inst = f;
        step("ld14", f, 0, 1);
        f = {ins(STORE, 14, 1, 2), NOP}; bus.f_inst = f;
        step("st_rs1", f, 1, 0);
        step("st_rs2", f, 1, 0);
        step("st_rs_go", f, 0, 1);

        // flush in SPLIT_LO drops the lower half
        h = ins(ADDI, 1, 0, 0); l = ins(ADD, 2, 1, 1); bus.f_inst = {h, l};
        step("fl_hi", {h, NOP}, 0, 0);
        bus.flush = 1'b1;
        step("fl_lo", {l, NOP}, 1, 1);
        bus.flush = 1'b0;
        f = {ins(ADD, 3, 4, 5), ins(ADD, 6, 7, 8)}; bus.f_inst = f;
        step("post_flush", f, 0, 1);

        // reset mid-split
        bus.f_inst = {h, l};
        step("rs_hi", {h, NOP}, 0, 0);
        rstn = 1'b0;
        step("rst_mid", {NOP, NOP}, 1, 0);
        rstn = 1'b1;
        bus.f_inst = f;
        step("post_rst", f, 0, 1);

        // reset clears a pending load
        f = {ins(LOAD, 20, 1, 0), NOP}; bus.f_inst = f;
        step("ld20", f, 0, 1);
        rstn = 1'b0;
        step("rst_ld", {NOP, NOP}, 1, 0);
        rstn = 1'b1;
        f = {ins(ADD, 21, 20, 0), NOP}; bus.f_inst = f;
        step("rst_sb_clr", f, 0, 1);

        // no valid bundle in PASS stalls
        bus.f_valid = 1'b0;
        step("no_valid", f, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
